// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM front-end types and defaults
package arm_pkg;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_AHEAD_DEFAULT = 32'd8;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: one outstanding request, single-entry decode buffer
module fetch_unit
    import arm_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_AHEAD = PC_AHEAD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic [31:0] pc_write,
    output logic        pc_w,
    output logic [15:0] fetch_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic [31:0]  pc_write_q, pc_write_d;
    logic         instr_valid_q, instr_valid_d;
    logic         pc_w_q, pc_w_d;
    logic [15:0]  fetch_count_q, fetch_count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_START;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            pc_write_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            pc_w_q        <= 1'b0;
            fetch_count_q <= 16'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            pc_write_q    <= pc_write_d;
            instr_valid_q <= instr_valid_d;
            pc_w_q        <= pc_w_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        pc_write_d    = pc_write_q;
        instr_valid_d = instr_valid_q;
        pc_w_d        = 1'b0;
        fetch_count_d = fetch_count_q;

        // A redirect overrides everything, including a same-cycle memory return.
        if (branch_valid) begin
            pc_d          = branch_target & 32'hFFFF_FFFC;
            instr_valid_d = 1'b0;
            state_d       = S_FETCH;
        end else begin
            case (state_q)
                S_START: state_d = S_FETCH;
                S_FETCH: begin
                    if (mem_ack) begin
                        instr_d       = mem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_w_d        = 1'b1;
                        pc_write_d    = pc_q + PC_AHEAD;
                        state_d       = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        pc_d          = pc_q + 32'd4;
                        instr_valid_d = 1'b0;
                        fetch_count_d = fetch_count_q + 16'd1;
                        state_d       = S_FETCH;
                    end
                end
                default: state_d = S_START;
            endcase
        end
    end

    // The request is a pure function of state so reset withdraws it asynchronously.
    assign mem_req     = (state_q == S_FETCH);
    assign mem_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign pc_write    = pc_write_q;
    assign pc_w        = pc_w_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr, mem_rdata, branch_target, instr, instr_pc, pc_write;
    logic        mem_req, mem_ack, branch_valid, stall, instr_valid, pc_w;
    logic [15:0] fetch_count;
    logic        rdata_fixed_en;
    logic [31:0] rdata_fixed;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign mem_rdata = rdata_fixed_en ? rdata_fixed : (mem_addr ^ 32'hE1A0_0000);

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (mem_addr),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .stall        (stall),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .pc_write     (pc_write),
        .pc_w         (pc_w),
        .fetch_count  (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: a fetch pointer, whether the core has started, and
    // whether one instruction is buffered awaiting decode.
    logic        m_started, m_have, m_pcw;
    logic [31:0] m_pc, m_instr, m_ipc, m_pcwrite;
    logic [15:0] m_consumed;
    logic [15:0] m_count_base;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_started  <= 1'b0;
            m_have     <= 1'b0;
            m_pc       <= 32'h0;
            m_instr    <= 32'h0;
            m_ipc      <= 32'h0;
            m_consumed <= 16'h0;
            m_pcw      <= 1'b0;
            m_pcwrite  <= 32'h0;
        end else begin
            m_pcw <= 1'b0;
            if (branch_valid) begin
                m_pc      <= {branch_target[31:2], 2'b00};
                m_have    <= 1'b0;
                m_started <= 1'b1;
            end else if (!m_started) begin
                m_started <= 1'b1;
            end else if (!m_have) begin
                if (mem_ack) begin
                    m_instr   <= mem_rdata;
                    m_ipc     <= m_pc;
                    m_have    <= 1'b1;
                    m_pcw     <= 1'b1;
                    m_pcwrite <= m_pc + 32'd8;
                end
            end else if (!stall) begin
                m_have     <= 1'b0;
                m_pc       <= m_pc + 32'd4;
                m_consumed <= m_consumed + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        chk("mdl_mem_req", {31'b0, mem_req}, {31'b0, m_started && !m_have});
        chk("mdl_mem_addr", mem_addr, m_pc);
        chk("mdl_instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
        chk("mdl_instr", instr, m_instr);
        chk("mdl_instr_pc", instr_pc, m_ipc);
        chk("mdl_pc_w", {31'b0, pc_w}, {31'b0, m_pcw});
        chk("mdl_pc_write", pc_write, m_pcwrite);
        chk("mdl_fetch_count", {16'b0, fetch_count}, {16'b0, 16'(m_count_base + m_consumed)});
    end

    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; mem_ack = 1'b0; branch_valid = 1'b0; branch_target = 32'h0;
        stall = 1'b0; rdata_fixed_en = 1'b0; rdata_fixed = 32'h0; m_count_base = 16'h0;
        cyc; cyc;
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_pc_write", pc_write, 32'h0);
        chk("rst_fetch_count", {16'b0, fetch_count}, 32'h0);
        chk("rst_instr", instr, 32'h0);

        // Back-to-back fetches with ack tied high
        rst = 1'b0; mem_ack = 1'b1;
        chk("start_no_req", {31'b0, mem_req}, 32'h0);
        cyc; chk("seq_req0", {31'b0, mem_req}, 32'h1); chk("seq_addr0", mem_addr, 32'h0);
        cyc; chk("seq_valid0", {31'b0, instr_valid}, 32'h1); chk("seq_pcw0", {31'b0, pc_w}, 32'h1);
        chk("seq_pcwrite0", pc_write, 32'h8); chk("seq_instr0", instr, 32'hE1A0_0000);
        cyc; chk("seq_addr1", mem_addr, 32'h4); chk("seq_valid_gap", {31'b0, instr_valid}, 32'h0);
        chk("seq_count1", {16'b0, fetch_count}, 32'h1);
        cyc; chk("seq_pcwrite1", pc_write, 32'hC); chk("seq_ipc1", instr_pc, 32'h4);
        cyc; chk("seq_addr2", mem_addr, 32'h8);
        cyc; chk("seq_pcwrite2", pc_write, 32'h10); chk("seq_valid2", {31'b0, instr_valid}, 32'h1);

        // Delayed ack at 0x100; the buffered instruction is dropped by the redirect
        mem_ack = 1'b0; branch_valid = 1'b1; branch_target = 32'h100;
        cyc; branch_valid = 1'b0;
        chk("br_drop_count", {16'b0, fetch_count}, 32'h2);
        for (int i = 0; i < 3; i++) begin
            chk("wait_req", {31'b0, mem_req}, 32'h1);
            chk("wait_addr", mem_addr, 32'h100);
            chk("wait_no_pcw", {31'b0, pc_w}, 32'h0);
            cyc;
        end
        chk("ack_req", {31'b0, mem_req}, 32'h1); chk("ack_addr", mem_addr, 32'h100);
        rdata_fixed_en = 1'b1; rdata_fixed = 32'hE3A0_0001; mem_ack = 1'b1;
        cyc; mem_ack = 1'b0; stall = 1'b1;
        chk("late_pcw", {31'b0, pc_w}, 32'h1); chk("late_pcwrite", pc_write, 32'h108);

        // Stall holds the buffered instruction
        for (int i = 0; i < 5; i++) begin
            cyc;
            chk("stall_instr", instr, 32'hE3A0_0001);
            chk("stall_ipc", instr_pc, 32'h100);
            chk("stall_valid", {31'b0, instr_valid}, 32'h1);
            chk("stall_count", {16'b0, fetch_count}, 32'h2);
            chk("stall_no_pcw", {31'b0, pc_w}, 32'h0);
        end
        stall = 1'b0;
        cyc; chk("unstall_count", {16'b0, fetch_count}, 32'h3); chk("unstall_addr", mem_addr, 32'h104);

        // Branch coincident with ack discards the data
        mem_ack = 1'b1; branch_valid = 1'b1; branch_target = 32'h203;
        cyc; branch_valid = 1'b0; mem_ack = 1'b0;
        chk("brack_addr", mem_addr, 32'h200); chk("brack_no_pcw", {31'b0, pc_w}, 32'h0);
        chk("brack_valid", {31'b0, instr_valid}, 32'h0); chk("brack_instr", instr, 32'hE3A0_0001);
        cyc; chk("brack_no_pcw2", {31'b0, pc_w}, 32'h0); chk("brack_addr2", mem_addr, 32'h200);

        // PC and counter wrap together
        branch_valid = 1'b1; branch_target = 32'hFFFF_FFFC;
        cyc; branch_valid = 1'b0; mem_ack = 1'b1;
        chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
        cyc; mem_ack = 1'b0;
        chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC); chk("wrap_pcwrite", pc_write, 32'h4);
        force dut.fetch_count_q = 16'hFFFF;
        m_count_base = 16'hFFFF - m_consumed;
        #1 release dut.fetch_count_q;
        chk("wrap_count_pre", {16'b0, fetch_count}, 32'hFFFF);
        cyc; chk("wrap_addr0", mem_addr, 32'h0); chk("wrap_count0", {16'b0, fetch_count}, 32'h0);

        // Asynchronous reset in the middle of an outstanding request
        cyc; #1;
        rst = 1'b1; m_count_base = 16'h0;
        #1;
        chk("arst_req", {31'b0, mem_req}, 32'h0); chk("arst_valid", {31'b0, instr_valid}, 32'h0);
        chk("arst_addr", mem_addr, 32'h0); chk("arst_count", {16'b0, fetch_count}, 32'h0);
        cyc; rst = 1'b0; mem_ack = 1'b1; rdata_fixed_en = 1'b0;
        chk("restart_start", {31'b0, mem_req}, 32'h0);
        cyc; chk("restart_req", {31'b0, mem_req}, 32'h1); chk("restart_addr", mem_addr, 32'h0);
        cyc; chk("restart_ipc", instr_pc, 32'h0); chk("restart_pcwrite", pc_write, 32'h8);

        // Branch while stalled drops the held instruction uncounted
        stall = 1'b1; mem_ack = 1'b0; branch_valid = 1'b1; branch_target = 32'h40;
        cyc; branch_valid = 1'b0; stall = 1'b0;
        chk("brstall_valid", {31'b0, instr_valid}, 32'h0);
        chk("brstall_count", {16'b0, fetch_count}, 32'h0);
        chk("brstall_addr", mem_addr, 32'h40);
        cyc; cyc;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
